grant_arbiter: RTL and testbench

Parametrised, registered N-channel arbiter with one-hot grant. It generalises the combinational one-hot `case` decoder into a sequential block: fixed-priority or round-robin selection, grant lock while the winner keeps requesting, optional hold-timeout with forced release, and a binary-encoded grant index. It sits between N requesters and one shared resource, for example a bus port or a memory bank.

---
 rtl/grant_arbiter.sv | 135 +++++++++++++
 tb/tb_grant_arbiter.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/grant_arbiter.sv
// +-----------------------------------------------------------------------+
// | grant_arbiter: registered N-channel one-hot arbiter, fixed priority   |
// | or round-robin, grant lock and optional hold timeout. Rev 1.0         |
// +-----------------------------------------------------------------------+
`default_nettype none

module grant_arbiter #(
   parameter int N        = 4,
   parameter int RR       = 1,
   parameter int MAX_HOLD = 0,
   parameter int IW       = $clog2(N)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [N-1:0]  req,
   output logic [N-1:0]  gnt,
   output logic [IW-1:0] gnt_idx,
   output logic          busy,
   output logic          timeout
);

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_GRANT = 1'b1
   } state_t;

   localparam logic [IW:0] N_W       = (IW+1)'(N);
   localparam bit          HOLD_EN   = (MAX_HOLD != 0);
   localparam logic [7:0]  HOLD_LAST = 8'(MAX_HOLD - 1);

   state_t        state_q, state_d;
   logic [N-1:0]  gnt_q, gnt_d;
   logic [IW-1:0] idx_q, idx_d;
   logic [IW-1:0] ptr_q, ptr_d;
   logic [7:0]    cnt_q, cnt_d;
   logic          busy_q, busy_d;
   logic          timeout_q, timeout_d;

   logic [IW-1:0] base;
   logic [N-1:0]  req_rot;
   logic [IW-1:0] off;
   logic [IW:0]   win_sum;
   logic [IW-1:0] win_idx;
   logic [IW:0]   ptr_inc;

   // Rotate the request vector so the scan always starts at bit 0, then
   // map the lowest set offset back to an absolute channel number.
   always_comb begin
      base    = (RR != 0) ? ptr_q : '0;
      req_rot = N'({req, req} >> base);
      off     = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (req_rot[i]) off = IW'(i);
      end
      win_sum = {1'b0, base} + {1'b0, off};
      if (win_sum >= N_W) win_sum = win_sum - N_W;
      win_idx = win_sum[IW-1:0];
      ptr_inc = {1'b0, win_idx} + 1'b1;
      if (ptr_inc == N_W) ptr_inc = '0;
   end

   always_comb begin
      state_d   = state_q;
      gnt_d     = gnt_q;
      idx_d     = idx_q;
      ptr_d     = ptr_q;
      cnt_d     = cnt_q;
      busy_d    = busy_q;
      timeout_d = 1'b0;
      case (state_q)
         ST_IDLE: begin
            gnt_d  = '0;
            busy_d = 1'b0;
            if (|req) begin
               state_d = ST_GRANT;
               gnt_d   = {{(N-1){1'b0}}, 1'b1} << win_idx;
               idx_d   = win_idx;
               busy_d  = 1'b1;
               cnt_d   = '0;
               if (RR != 0) ptr_d = ptr_inc[IW-1:0];
            end
         end
         ST_GRANT: begin
            // A dropped request wins over a coincident timeout.
            if (!req[idx_q]) begin
               state_d = ST_IDLE;
               gnt_d   = '0;
               busy_d  = 1'b0;
            end else if (HOLD_EN && (cnt_q == HOLD_LAST)) begin
               state_d   = ST_IDLE;
               gnt_d     = '0;
               busy_d    = 1'b0;
               timeout_d = 1'b1;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         default: begin
            state_d = ST_IDLE;
            gnt_d   = '0;
            idx_d   = '0;
            busy_d  = 1'b0;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         gnt_q     <= '0;
         idx_q     <= '0;
         ptr_q     <= '0;
         cnt_q     <= '0;
         busy_q    <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         gnt_q     <= gnt_d;
         idx_q     <= idx_d;
         ptr_q     <= ptr_d;
         cnt_q     <= cnt_d;
         busy_q    <= busy_d;
         timeout_q <= timeout_d;
      end
   end

   assign gnt     = gnt_q;
   assign gnt_idx = idx_q;
   assign busy    = busy_q;
   assign timeout = timeout_q;

endmodule

`default_nettype wire

// File: tb/tb_grant_arbiter.sv
// +-----------------------------------------------------------------------+
// | tb_grant_arbiter: directed-vector bench for grant_arbiter in four     |
// | configurations. Rev 1.0                                               |
// +-----------------------------------------------------------------------+
`default_nettype none

module tb_grant_arbiter;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] req_fp, req_rr, req_to;
   logic [7:0] req_8;

   logic [3:0] gnt_fp, gnt_rr, gnt_to;
   logic [7:0] gnt_8;
   logic [1:0] idx_fp, idx_rr, idx_to;
   logic [2:0] idx_8;
   logic       busy_fp, busy_rr, busy_to, busy_8;
   logic       to_fp, to_rr, to_to, to_8;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   grant_arbiter #(.N(4), .RR(0), .MAX_HOLD(0)) u_fp (
      .clk(clk), .rst(rst), .req(req_fp), .gnt(gnt_fp),
      .gnt_idx(idx_fp), .busy(busy_fp), .timeout(to_fp));

   grant_arbiter #(.N(4), .RR(1), .MAX_HOLD(0)) u_rr (
      .clk(clk), .rst(rst), .req(req_rr), .gnt(gnt_rr),
      .gnt_idx(idx_rr), .busy(busy_rr), .timeout(to_rr));

   grant_arbiter #(.N(8), .RR(1), .MAX_HOLD(0)) u_rr8 (
      .clk(clk), .rst(rst), .req(req_8), .gnt(gnt_8),
      .gnt_idx(idx_8), .busy(busy_8), .timeout(to_8));

   grant_arbiter #(.N(4), .RR(1), .MAX_HOLD(4)) u_to (
      .clk(clk), .rst(rst), .req(req_to), .gnt(gnt_to),
      .gnt_idx(idx_to), .busy(busy_to), .timeout(to_to));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst    = 1'b1;
      req_fp = '0;
      req_rr = '0;
      req_to = '0;
      req_8  = '0;
      tick();
      tick();
      chk("rst_gnt_fp",  32'(gnt_fp),  32'h0);
      chk("rst_idx_fp",  32'(idx_fp),  32'h0);
      chk("rst_busy_rr", 32'(busy_rr), 32'h0);
      chk("rst_to_to",   32'(to_to),   32'h0);
      chk("rst_gnt_8",   32'(gnt_8),   32'h0);
      rst = 1'b0;

      // fixed priority
      req_fp = 4'b0110;
      tick();
      chk("fp_gnt",  32'(gnt_fp),  32'h2);
      chk("fp_idx",  32'(idx_fp),  32'h1);
      chk("fp_busy", 32'(busy_fp), 32'h1);
      req_fp = 4'b0100;
      tick();
      chk("fp_rel_gnt",  32'(gnt_fp),  32'h0);
      chk("fp_rel_busy", 32'(busy_fp), 32'h0);
      chk("fp_idx_hold", 32'(idx_fp),  32'h1);
      tick();
      chk("fp_gnt2", 32'(gnt_fp), 32'h4);
      chk("fp_idx2", 32'(idx_fp), 32'h2);
      req_fp = 4'b0000;
      tick();

      // round-robin fairness: order 0,1,2,3,0
      req_rr = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         tick();
         chk("rr_gnt",  32'(gnt_rr), 32'(4'b0001 << (k % 4)));
         chk("rr_idx",  32'(idx_rr), 32'(k % 4));
         tick();
         chk("rr_hold", 32'(gnt_rr), 32'(4'b0001 << (k % 4)));
         req_rr[k % 4] = 1'b0;
         tick();
         chk("rr_gap_gnt",  32'(gnt_rr),  32'h0);
         chk("rr_gap_busy", 32'(busy_rr), 32'h0);
         req_rr = (k < 4) ? 4'b1111 : 4'b0000;
      end

      // pointer wrap, N=8
      req_8 = 8'h80;
      tick();
      chk("w_gnt7", 32'(gnt_8), 32'h80);
      chk("w_idx7", 32'(idx_8), 32'h7);
      req_8 = 8'h81;
      tick();
      chk("w_nopreempt", 32'(gnt_8), 32'h80);
      req_8 = 8'h01;
      tick();
      chk("w_rel", 32'(gnt_8), 32'h0);
      tick();
      chk("w_gnt0", 32'(gnt_8), 32'h01);
      chk("w_idx0", 32'(idx_8), 32'h0);
      req_8 = 8'h00;
      tick();
      req_8 = 8'h81;
      tick();
      chk("w_scan_gnt7", 32'(gnt_8), 32'h80);
      chk("w_scan_idx7", 32'(idx_8), 32'h7);
      req_8 = 8'h01;
      tick();
      chk("w_rel2", 32'(gnt_8), 32'h0);
      req_8 = 8'h81;
      tick();
      chk("w_wrap_gnt0", 32'(gnt_8), 32'h01);
      chk("w_wrap_idx0", 32'(idx_8), 32'h0);
      req_8 = 8'h00;
      tick();

      // timeout with MAX_HOLD=4
      req_to = 4'b0011;
      for (int r = 0; r < 2; r++) begin
         for (int c = 0; c < 4; c++) begin
            tick();
            chk("to_gnt",  32'(gnt_to), 32'(4'b0001 << r));
            chk("to_low",  32'(to_to),  32'h0);
         end
         tick();
         chk("to_rel_gnt", 32'(gnt_to),  32'h0);
         chk("to_pulse",   32'(to_to),   32'h1);
         chk("to_busy",    32'(busy_to), 32'h0);
      end
      tick();
      chk("to_back_gnt", 32'(gnt_to), 32'h1);
      chk("to_pulse_end", 32'(to_to), 32'h0);
      tick();
      tick();
      tick();
      chk("to_c4_gnt", 32'(gnt_to), 32'h1);
      req_to = 4'b0010;
      tick();
      chk("to_coinc_gnt", 32'(gnt_to), 32'h0);
      chk("to_coinc_to",  32'(to_to),  32'h0);
      tick();
      chk("to_next_gnt", 32'(gnt_to), 32'h2);
      req_to = 4'b0000;
      tick();

      // no request
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("idle_gnt",  32'(gnt_fp),  32'h0);
         chk("idle_busy", 32'(busy_fp), 32'h0);
         chk("idle_to",   32'(to_fp),   32'h0);
      end

      // reset in the middle of a grant (u_rr ptr is 1 here)
      req_rr = 4'b0100;
      tick();
      chk("mr_gnt", 32'(gnt_rr), 32'h4);
      rst    = 1'b1;
      req_rr = 4'b1111;
      tick();
      chk("mr_gnt0",  32'(gnt_rr),  32'h0);
      chk("mr_idx0",  32'(idx_rr),  32'h0);
      chk("mr_busy0", 32'(busy_rr), 32'h0);
      chk("mr_to0",   32'(to_rr),   32'h0);
      rst = 1'b0;
      tick();
      chk("mr_first_gnt", 32'(gnt_rr), 32'h1);
      chk("mr_first_idx", 32'(idx_rr), 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

`default_nettype wire
